// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner
//   Time-multiplexed driver for an NDIGITS-digit common seven-segment display.
//   A hex value is offered through a valid/ready handshake and held in a
//   pending register. It is copied into the display register only at a frame
//   boundary, so one scan never mixes two values. Each digit slot lasts
//   PRESCALE cycles. The first BLANK cycles of a slot are dark to suppress
//   ghosting between digits.
//
// Parameters
//   NDIGITS   number of digits (1..8)
//   PRESCALE  clock cycles per digit slot (must exceed BLANK)
//   BLANK     dark cycles at the start of every slot (>= 1)
//
// Ports
//   clk         clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   load_valid  a new display value is offered
//   load_ready  the pending register is empty and can take a value
//   load_data   hex value, nibble i drives digit i (digit 0 = least significant)
//   lz_blank    leading-zero blanking enable, sampled every cycle
//   seg         registered active-high segments {a,b,c,d,e,f,g}
//   an          registered active-high one-hot digit enable
//   frame_done  one-cycle pulse aligned with the last output cycle of a scan
module sevenseg_scanner #(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_data,
  input  logic                   lz_blank,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
  localparam logic [DW-1:0] DIG_LAST = DW'(NDIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  // Hex to seven-segment, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          dig_q, dig_d;
  state_e                 state_q, state_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d;
  logic [4*NDIGITS-1:0]   pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   frame_done_q, frame_done_d;

  logic                   accept;
  logic                   cnt_wrap;
  logic                   zero_run;
  logic                   lead_zero;
  logic [3:0]             nib;
  logic [NDIGITS-1:0]     an_sel;

  always_comb begin
    accept   = load_valid && !pend_full_q;
    cnt_wrap = (cnt_q == CNT_LAST);

    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    dig_d = dig_q;
    if (cnt_wrap) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    // State tracks the counter value it will be paired with next cycle.
    state_d = (cnt_d >= CNT_SHOW) ? ST_SHOW : ST_BLANK;

    frame_done_d = cnt_wrap && (dig_q == DIG_LAST);

    // The transfer happens while frame_done is high: the counter already sits
    // in the first (always dark) cycle of digit 0, so the old value finishes
    // its frame and the new one is used from the first lit cycle onward.
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (accept) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end else if (frame_done_q && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end

    // Walk from the most significant digit down, tracking whether every
    // nibble at or above the current position is zero.
    zero_run  = 1'b1;
    lead_zero = 1'b0;
    nib       = '0;
    an_sel    = '0;
    for (int unsigned j = 0; j < NDIGITS; j++) begin
      zero_run = zero_run && (disp_q[4*(NDIGITS-1-j) +: 4] == 4'h0);
      if (dig_q == DW'(NDIGITS - 1 - j)) begin
        nib                   = disp_q[4*(NDIGITS-1-j) +: 4];
        lead_zero             = zero_run && (j != NDIGITS - 1);
        an_sel[NDIGITS-1-j]   = 1'b1;
      end
    end

    seg_d = '0;
    an_d  = '0;
    if (state_q == ST_SHOW && !(lz_blank && lead_zero)) begin
      seg_d = hex7(nib);
      an_d  = an_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      state_q      <= ST_BLANK;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = !pend_full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Testbench for sevenseg_scanner with NDIGITS=4, PRESCALE=8, BLANK=2.
// A frame is 32 cycles. Sample m (1..32) after a boundary shows slot
// position m-1: digit (m-1)/8, count (m-1)%8, dark while count < 2.
module tb_sevenseg_scanner;

  logic        clk;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [15:0]      data;
    logic             lz;
    logic [3:0][6:0]  seg;   // expected pattern per digit, index = digit
    logic [3:0]       lit;   // digit lit during SHOW
  } vec_t;

  vec_t tbl [7];
  vec_t row_zero, row_a, row_5, prev;

  sevenseg_scanner #(
    .NDIGITS (4),
    .PRESCALE(8),
    .BLANK   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Checks samples m0..m1 of a frame; caller has already advanced to m0.
  // rdy < 0 skips the load_ready check.
  task automatic check_frame(input vec_t r, input int m0, input int m1, input int rdy);
    int pos, d, c;
    logic [6:0] es;
    logic [3:0] ea;
    lz_blank = r.lz;
    for (int m = m0; m <= m1; m++) begin
      if (m > m0) tick();
      pos = m - 1;
      d   = pos / 8;
      c   = pos % 8;
      if (c < 2 || !r.lit[d]) begin
        es = '0;
        ea = '0;
      end else begin
        es = r.seg[d];
        ea = 4'b0001 << d;
      end
      chk($sformatf("seg[%h] m=%0d", r.data, m), {25'd0, seg}, {25'd0, es});
      chk($sformatf("an[%h] m=%0d", r.data, m), {28'd0, an}, {28'd0, ea});
      chk($sformatf("frame_done m=%0d", m), {31'd0, frame_done}, {31'd0, (m == 32)});
      if (rdy >= 0)
        chk($sformatf("load_ready m=%0d", m), {31'd0, load_ready}, {31'd0, rdy[0]});
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    row_zero = '{16'h0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b1111};
    row_a    = '{16'hAAAA, 1'b0, {7'b1110111, 7'b1110111, 7'b1110111, 7'b1110111}, 4'b1111};
    row_5    = '{16'h5555, 1'b0, {7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011}, 4'b1111};

    tbl[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1111};
    tbl[1] = '{16'h0007, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}, 4'b0001};
    tbl[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0001};
    tbl[3] = '{16'h00F0, 1'b1, {7'b0000000, 7'b0000000, 7'b1000111, 7'b1111110}, 4'b0011};
    tbl[4] = '{16'h0B0C, 1'b1, {7'b0000000, 7'b0011111, 7'b1111110, 7'b1001110}, 4'b0111};
    tbl[5] = '{16'h89DE, 1'b0, {7'b1111111, 7'b1111011, 7'b0111101, 7'b1001111}, 4'b1111};
    tbl[6] = '{16'h0056, 1'b0, {7'b1111110, 7'b1111110, 7'b1011011, 7'b1011111}, 4'b1111};

    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    lz_blank   = 1'b0;

    // Reset state, before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst seg", {25'd0, seg}, 32'd0);
    chk("rst an", {28'd0, an}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst load_ready", {31'd0, load_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle scanning of the reset value: two full frames.
    tick();
    check_frame(row_zero, 1, 32, 1);
    tick();
    check_frame(row_zero, 1, 32, 1);
    prev = row_zero;

    // Each value is offered in the boundary cycle: accepted there, the
    // following frame still shows the old value, the one after shows it.
    for (int unsigned i = 0; i < 7; i++) begin
      lz_blank   = prev.lz;
      load_valid = 1'b1;
      load_data  = tbl[i].data;
      tick();
      load_valid = 1'b0;
      load_data  = 16'hFFFF;
      check_frame(prev, 1, 32, 0);
      tick();
      check_frame(tbl[i], 1, 32, 1);
      prev = tbl[i];
    end

    // Held valid: AAAA offered mid-frame, then 5555 kept on the bus.
    tick();
    check_frame(prev, 1, 10, 1);
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    tick();
    load_data  = 16'h5555;
    check_frame(prev, 11, 32, 0);
    tick();
    chk("ready after transfer", {31'd0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    check_frame(row_a, 2, 32, 0);
    tick();
    check_frame(row_5, 1, 32, 1);

    // Reset during SHOW of digit 2 with 1234 pending.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    check_frame(row_5, 1, 20, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst seg", {25'd0, seg}, 32'd0);
    chk("midrst an", {28'd0, an}, 32'd0);
    chk("midrst frame_done", {31'd0, frame_done}, 32'd0);
    chk("midrst load_ready", {31'd0, load_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_frame(row_zero, 1, 32, 1);
    tick();
    check_frame(row_zero, 1, 32, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
